// File: rtl/exec_alu_if.sv
// exec_alu_if: decode-side and writeback-side handshake bundle for the exec_alu stage.
interface exec_alu_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic        in_is_imm;
    logic [63:0] in_op1;
    logic [63:0] in_op2;
    logic        in_mem_acc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [63:0] out_result;
    logic        out_mem_acc;
    logic        busy;
    modport slave (
        input  in_valid, in_rd, in_funct3, in_funct7, in_is_imm, in_op1, in_op2, in_mem_acc, out_ready,
        output in_ready, out_valid, out_rd, out_funct3, out_result, out_mem_acc, busy
    );
    modport master (
        output in_valid, in_rd, in_funct3, in_funct7, in_is_imm, in_op1, in_op2, in_mem_acc, out_ready,
        input  in_ready, out_valid, out_rd, out_funct3, out_result, out_mem_acc, busy
    );
endinterface

// File: rtl/exec_alu.sv
// exec_alu: RV64 execute stage with a one-entry valid/ready output register.
// Defining EXEC_MUL_EN adds an iterative 64-step shift-add multiplier for MUL.
module exec_alu #(parameter int XLEN = 64) (
    input logic      CLK,
    input logic      RST_N,
    exec_alu_if.slave io
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
    state_e state_q, state_d;
    logic valid_q, valid_d, mem_acc_q, mem_acc_d;
    logic [4:0] rd_q, rd_d;
    logic [2:0] funct3_q, funct3_d;
    logic [XLEN-1:0] result_q, result_d, alu_res;
    logic arith, sub, start_mul, accept, out_free;
    logic [5:0] sh;
`ifdef EXEC_MUL_EN
    logic [63:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [6:0] cnt_q, cnt_d;
    logic [4:0] mul_rd_q, mul_rd_d;
    logic mul_op;
    assign mul_op = !io.in_is_imm && !io.in_mem_acc && io.in_funct7 == 7'b0000001;
    assign start_mul = accept && mul_op && io.in_funct3 == 3'b000;
`else
    assign start_mul = 1'b0;
`endif
    assign out_free = !valid_q || io.out_ready;
    assign io.in_ready = state_q == IDLE && out_free;
    assign accept = io.in_valid && io.in_ready;
    assign io.out_valid = valid_q;
    assign io.out_rd = rd_q;
    assign io.out_funct3 = funct3_q;
    assign io.out_result = result_q;
    assign io.out_mem_acc = mem_acc_q;
    assign io.busy = state_q != IDLE;
    always_comb begin
        sh = io.in_op2[5:0];
        arith = io.in_is_imm ? io.in_op2[10] : io.in_funct7[5];
        sub = !io.in_is_imm && io.in_funct7[5];
        alu_res = '0;
        case (io.in_funct3)
            3'b000: alu_res = sub ? io.in_op1 - io.in_op2 : io.in_op1 + io.in_op2;
            3'b001: alu_res = io.in_op1 << sh;
            3'b010: alu_res = {63'd0, $signed(io.in_op1) < $signed(io.in_op2)};
            3'b011: alu_res = {63'd0, io.in_op1 < io.in_op2};
            3'b100: alu_res = io.in_op1 ^ io.in_op2;
            3'b101: alu_res = arith ? 64'($signed(io.in_op1) >>> sh) : io.in_op1 >> sh;
            3'b110: alu_res = io.in_op1 | io.in_op2;
            default: alu_res = io.in_op1 & io.in_op2;
        endcase
`ifdef EXEC_MUL_EN
        if (mul_op)
            alu_res = '0;
`endif
        if (io.in_mem_acc)
            alu_res = io.in_op1 + io.in_op2;
    end
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        rd_d = rd_q;
        funct3_d = funct3_q;
        result_d = result_q;
        mem_acc_d = mem_acc_q;
        if (valid_q && io.out_ready)
            valid_d = 1'b0;
        if (accept && !start_mul) begin
            valid_d = 1'b1;
            rd_d = io.in_rd;
            funct3_d = io.in_funct3;
            result_d = alu_res;
            mem_acc_d = io.in_mem_acc;
        end
`ifdef EXEC_MUL_EN
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        mul_rd_d = mul_rd_q;
        case (state_q)
            IDLE: if (start_mul) begin
                state_d = MUL;
                mcand_d = io.in_op1;
                mplier_d = io.in_op2;
                acc_d = '0;
                cnt_d = '0;
                mul_rd_d = io.in_rd;
            end
            MUL: begin
                acc_d = acc_q + (mplier_q[cnt_q[5:0]] ? mcand_q : 64'd0);
                mcand_d = mcand_q << 1;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'd63)
                    state_d = DONE;
            end
            DONE: if (out_free) begin
                state_d = IDLE;
                valid_d = 1'b1;
                rd_d = mul_rd_q;
                funct3_d = 3'b000;
                result_d = acc_q;
                mem_acc_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
`else
        state_d = IDLE;
`endif
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            rd_q <= '0;
            funct3_q <= '0;
            result_q <= '0;
            mem_acc_q <= 1'b0;
`ifdef EXEC_MUL_EN
            mcand_q <= '0;
            mplier_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            mul_rd_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rd_q <= rd_d;
            funct3_q <= funct3_d;
            result_q <= result_d;
            mem_acc_q <= mem_acc_d;
`ifdef EXEC_MUL_EN
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            mul_rd_q <= mul_rd_d;
`endif
        end
    end
endmodule
